// File: rtl/gpio_regs.sv
// rtl/gpio_regs.sv - 32-bit GPIO register block with optional rising-edge interrupt
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   sel, addr, we, re   register access (we/re qualified by sel), word offset
//   wdata, rdata        write data in; registered read data out (held between reads)
//   rvalid              one-cycle pulse marking rdata valid
//   gpio_i              asynchronous pad inputs (two-flop synchronized)
//   gpio_o, gpio_oe     pad output values (OUT) and output enables (DIR, 1 = drive)
//   irq                 level interrupt, OR of IRQ_STAT & IRQ_EN
//
// Register map: 0 OUT (RW), 1 DIR (RW), 2 IN (RO), 3 IRQ_EN (RW), 4 IRQ_STAT (RW1C).
// Build option: define GPIO_IRQ_EN to implement IRQ_EN, IRQ_STAT, edge detect and irq.
// Without it offsets 3 and 4 are reserved and irq is tied low.

module gpio_regs (
    input  logic        clk,
    input  logic        rst,
    input  logic        sel,
    input  logic [4:0]  addr,
    input  logic        we,
    input  logic        re,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        rvalid,
    input  logic [31:0] gpio_i,
    output logic [31:0] gpio_o,
    output logic [31:0] gpio_oe,
    output logic        irq
);

    localparam logic [4:0] ADDR_OUT      = 5'd0;
    localparam logic [4:0] ADDR_DIR      = 5'd1;
    localparam logic [4:0] ADDR_IN       = 5'd2;
    localparam logic [4:0] ADDR_IRQ_EN   = 5'd3;
    localparam logic [4:0] ADDR_IRQ_STAT = 5'd4;

    logic        wr_en;
    logic        rd_en;
    logic [31:0] out_q;
    logic [31:0] dir_q;
    logic [31:0] sync1_q;
    logic [31:0] sync2_q;
    logic [31:0] rd_val;

    assign wr_en   = sel & we;
    assign rd_en   = sel & re;
    assign gpio_o  = out_q;
    assign gpio_oe = dir_q;

    // Pins are sampled regardless of DIR so driven values loop back into IN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= gpio_i;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= '0;
            dir_q <= '0;
        end else if (wr_en) begin
            if (addr == ADDR_OUT) out_q <= wdata;
            if (addr == ADDR_DIR) dir_q <= wdata;
        end
    end

`ifdef GPIO_IRQ_EN
    logic [31:0] prev_q;
    logic [31:0] irq_en_q;
    logic [31:0] irq_stat_q;
    logic [31:0] rise;
    logic [31:0] stat_clr;

    assign rise     = sync2_q & ~prev_q;
    assign stat_clr = (wr_en && addr == ADDR_IRQ_STAT) ? wdata : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q     <= '0;
            irq_en_q   <= '0;
            irq_stat_q <= '0;
        end else begin
            prev_q <= sync2_q;
            if (wr_en && addr == ADDR_IRQ_EN) irq_en_q <= wdata;
            // A new rise wins over a same-cycle write-one-to-clear.
            irq_stat_q <= (irq_stat_q & ~stat_clr) | rise;
        end
    end

    assign irq = |(irq_stat_q & irq_en_q);
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        rd_val = '0;
        case (addr)
            ADDR_OUT:      rd_val = out_q;
            ADDR_DIR:      rd_val = dir_q;
            ADDR_IN:       rd_val = sync2_q;
`ifdef GPIO_IRQ_EN
            ADDR_IRQ_EN:   rd_val = irq_en_q;
            ADDR_IRQ_STAT: rd_val = irq_stat_q;
`endif
            default:       rd_val = '0;
        endcase
    end

    // Read captures pre-write register values, so a same-cycle write/read
    // returns the old contents. rdata holds between reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= rd_en;
            if (rd_en) rdata <= rd_val;
        end
    end

endmodule

// File: tb/tb_gpio_regs.sv
// tb/tb_gpio_regs.sv - randomized and directed checks of gpio_regs against a reference model

module tb_gpio_regs;

`ifdef GPIO_IRQ_EN
    localparam bit HAS_IRQ = 1'b1;
`else
    localparam bit HAS_IRQ = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic [4:0]  addr = '0;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        rvalid;
    logic [31:0] gpio_i = '0;
    logic [31:0] gpio_o;
    logic [31:0] gpio_oe;
    logic        irq;

    int n_cmp  = 0;
    int n_fail = 0;
    bit run    = 1'b0;

    gpio_regs dut (
        .clk     (clk),
        .rst     (rst),
        .sel     (sel),
        .addr    (addr),
        .we      (we),
        .re      (re),
        .wdata   (wdata),
        .rdata   (rdata),
        .rvalid  (rvalid),
        .gpio_i  (gpio_i),
        .gpio_o  (gpio_o),
        .gpio_oe (gpio_oe),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    // Reference model: registers as plain values; the pin history holds
    // gpio_i as seen at the last three clock edges (index 0 = newest).
    // IN is the sample from one edge before the newest, and a rise is that
    // sample being 1 while the even older one was 0.
    logic [31:0] m_out = '0, m_dir = '0, m_en = '0, m_stat = '0;
    logic [31:0] m_rdata = '0;
    logic        m_rvalid = 1'b0;
    logic [31:0] smp [3] = '{default: '0};
    logic [31:0] m_in, m_rise, m_rv;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_out = '0; m_dir = '0; m_en = '0; m_stat = '0;
            m_rdata = '0; m_rvalid = 1'b0;
            smp[0] = '0; smp[1] = '0; smp[2] = '0;
        end else begin
            m_in   = smp[1];
            m_rise = smp[1] & ~smp[2];
            if (sel && re) begin
                case (addr)
                    5'd0:    m_rv = m_out;
                    5'd1:    m_rv = m_dir;
                    5'd2:    m_rv = m_in;
                    5'd3:    m_rv = HAS_IRQ ? m_en : 32'h0;
                    5'd4:    m_rv = HAS_IRQ ? m_stat : 32'h0;
                    default: m_rv = 32'h0;
                endcase
                m_rdata  = m_rv;
                m_rvalid = 1'b1;
            end else begin
                m_rvalid = 1'b0;
            end
            if (sel && we) begin
                if (addr == 5'd0) m_out = wdata;
                if (addr == 5'd1) m_dir = wdata;
                if (HAS_IRQ && addr == 5'd3) m_en = wdata;
                if (HAS_IRQ && addr == 5'd4) m_stat = m_stat & ~wdata;
            end
            if (HAS_IRQ) m_stat = m_stat | m_rise;
            smp[2] = smp[1];
            smp[1] = smp[0];
            smp[0] = gpio_i;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (run) begin
            chk("gpio_o", gpio_o, m_out);
            chk("gpio_oe", gpio_oe, m_dir);
            chk("rvalid", {31'b0, rvalid}, {31'b0, m_rvalid});
            chk("rdata", rdata, m_rdata);
            chk("irq", {31'b0, irq}, {31'b0, |(m_stat & m_en)});
        end
    end

    task automatic bus(input logic s, input logic w, input logic r,
                       input logic [4:0] a, input logic [31:0] d);
        sel = s; we = w; re = r; addr = a; wdata = d;
        @(posedge clk); #2;
        sel = 1'b0; we = 1'b0; re = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk); #2;
    endtask

    initial begin
        #23;
        chk("reset_gpio_o", gpio_o, 32'h0);
        chk("reset_rvalid", {31'b0, rvalid}, 32'h0);
        chk("reset_irq", {31'b0, irq}, 32'h0);
        @(posedge clk); #2;
        rst = 1'b0;
        run = 1'b1;

        bus(1, 1, 0, 5'd0, 32'hA5A5_0F0F);
        chk("lit_gpio_o", gpio_o, 32'hA5A5_0F0F);
        bus(1, 1, 0, 5'd1, 32'hFFFF_0000);
        chk("lit_gpio_oe", gpio_oe, 32'hFFFF_0000);
        bus(1, 0, 1, 5'd0, 32'h0);
        chk("lit_rd_out", rdata, 32'hA5A5_0F0F);
        chk("lit_rd_out_v", {31'b0, rvalid}, 32'h1);
        tick();
        chk("lit_rvalid_drop", {31'b0, rvalid}, 32'h0);
        chk("lit_rdata_hold", rdata, 32'hA5A5_0F0F);
        bus(1, 0, 1, 5'd1, 32'h0);
        chk("lit_rd_dir", rdata, 32'hFFFF_0000);
        bus(1, 0, 1, 5'd7, 32'h0);
        chk("lit_rd_rsvd", rdata, 32'h0);
        chk("lit_rd_rsvd_v", {31'b0, rvalid}, 32'h1);
        bus(0, 1, 1, 5'd0, 32'h1234_5678);
        chk("lit_nosel_out", gpio_o, 32'hA5A5_0F0F);
        chk("lit_nosel_rv", {31'b0, rvalid}, 32'h0);
        bus(1, 1, 1, 5'd0, 32'h0000_1111);
        chk("lit_rw_old", rdata, 32'hA5A5_0F0F);
        chk("lit_rw_new", gpio_o, 32'h0000_1111);

        // Pin 0 rises just after edge N.
        gpio_i = 32'h1;
        tick();                          // edge N+1
        bus(1, 0, 1, 5'd2, 32'h0);       // edge N+2 samples IN before it updates
        chk("lit_in_early", rdata, 32'h0);
        bus(1, 0, 1, 5'd2, 32'h0);       // edge N+3 sees IN as of edge N+2
        chk("lit_in_late", rdata, 32'h1);
        bus(1, 0, 1, 5'd4, 32'h0);       // edge N+4 sees STAT set at edge N+3
        chk("lit_stat0", rdata, HAS_IRQ ? 32'h1 : 32'h0);

        bus(1, 1, 0, 5'd3, 32'h1);
        chk("lit_irq_on", {31'b0, irq}, HAS_IRQ ? 32'h1 : 32'h0);
        bus(1, 1, 0, 5'd4, 32'h0);
        chk("lit_irq_keep", {31'b0, irq}, HAS_IRQ ? 32'h1 : 32'h0);
        bus(1, 1, 0, 5'd4, 32'h1);
        chk("lit_irq_clr", {31'b0, irq}, 32'h0);

        bus(1, 1, 0, 5'd4, 32'hFFFF_FFFF);
        gpio_i = 32'h9;                  // pin 3 rises just after edge M
        tick();
        tick();                          // rise[3] now high
        bus(1, 1, 0, 5'd4, 32'h8);       // W1C of bit 3 on the setting edge
        bus(1, 0, 1, 5'd4, 32'h0);
        chk("lit_set_prio", rdata, HAS_IRQ ? 32'h8 : 32'h0);

        // Asynchronous reset in the middle of a pending read response.
        sel = 1'b1; re = 1'b1; addr = 5'd0;
        @(posedge clk); #1;
        chk("lit_pend_rv", {31'b0, rvalid}, 32'h1);
        sel = 1'b0; re = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("lit_arst_rv", {31'b0, rvalid}, 32'h0);
        chk("lit_arst_rd", rdata, 32'h0);
        chk("lit_arst_o", gpio_o, 32'h0);
        chk("lit_arst_oe", gpio_oe, 32'h0);
        chk("lit_arst_irq", {31'b0, irq}, 32'h0);
        @(posedge clk); #2;
        rst = 1'b0;
        tick();
        chk("lit_post_rst_rv", {31'b0, rvalid}, 32'h0);

        for (int i = 0; i < 600; i++) begin
            sel   = ($urandom_range(0, 3) != 0);
            we    = $urandom_range(0, 1);
            re    = $urandom_range(0, 1);
            addr  = 5'($urandom_range(0, 8));
            wdata = $urandom;
            if ($urandom_range(0, 3) == 0) gpio_i = $urandom;
            tick();
        end
        sel = 1'b0; we = 1'b0; re = 1'b0;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
